// File: rtl/sipo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sipo_ctrl_pkg
// Shared definitions for the framed serial receive controller:
//   sipo_state_t    - controller FSM state encoding
//   SIPO_START_BIT  - line value that marks the start of a frame
//   SIPO_DEF_WIDTH  - default number of data bits per frame
// -----------------------------------------------------------------------------
package sipo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10
    } sipo_state_t;

    localparam logic SIPO_START_BIT = 1'b1;
    localparam int   SIPO_DEF_WIDTH = 4;

endpackage

// File: rtl/sipo_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl_if
// Parallel word output port of the receive controller (valid/ready).
//   q        - received word, first serial data bit in q[WIDTH-1]
//   q_valid  - q/par_err hold a word the consumer has not yet taken
//   q_ready  - consumer accepts the word when q_valid && q_ready
//   par_err  - parity mismatch for the word in q
// Modports: master = controller side, slave = consumer side.
// -----------------------------------------------------------------------------
interface sipo_frame_ctrl_if
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = SIPO_DEF_WIDTH
);

    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             par_err;

    modport master (output q, output q_valid, output par_err, input q_ready);
    modport slave  (input q, input q_valid, input par_err, output q_ready);

endinterface

// File: rtl/sipo_shreg.sv
// -----------------------------------------------------------------------------
// sipo_shreg
// Serial-in/parallel-out shift register, shifting toward the MSB so the first
// bit shifted in ends up in sr[WIDTH-1].
//   clk, rst  - clock, asynchronous active-low reset
//   clr       - synchronous clear (takes priority over en)
//   en        - shift d in on this edge
//   d         - serial input bit
//   sr        - register contents
// -----------------------------------------------------------------------------
module sipo_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] sr
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr <= {sr[WIDTH-2:0], d};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
// Framed serial receiver: waits for a start bit on the strobed line, shifts in
// WIDTH data bits MSB-first, optionally checks an even-parity bit, and offers
// the word on a registered valid/ready port.
//   clk, rst  - clock, asynchronous active-low reset
//   d, bit_en - serial data and its bit strobe (d ignored when bit_en=0)
//   ovr       - sticky overrun: a word completed while the output was full
//   ovr_clr   - clears ovr (a simultaneous overrun wins)
//   busy      - a frame is in progress
//   out       - word output port (q, q_valid, q_ready, par_err)
// -----------------------------------------------------------------------------
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH     = SIPO_DEF_WIDTH,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d,
    input  logic                bit_en,
    input  logic                ovr_clr,
    output logic                ovr,
    output logic                busy,
    sipo_frame_ctrl_if.master   out
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    sipo_state_t      state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;

    logic             shreg_clr;
    logic             shreg_en;
    logic             complete;
    logic             perr;
    logic [WIDTH-1:0] word;
    logic             slot_free;

    sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk (clk),
        .rst (rst),
        .clr (shreg_clr),
        .en  (shreg_en),
        .d   (d),
        .sr  (sr)
    );

    // The last data bit is still in flight when a non-parity frame completes,
    // so the delivered word is the shift register with d appended.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        shreg_clr = 1'b0;
        shreg_en  = 1'b0;
        complete  = 1'b0;
        perr      = 1'b0;
        word      = {sr[WIDTH-2:0], d};
        case (state)
            IDLE:   shreg_clr = bit_en && (d == SIPO_START_BIT);
            SHIFT: begin
                shreg_en = bit_en;
                complete = bit_en && (cnt == CNT_LAST) && !PARITY_EN;
            end
            PARITY: begin
                complete = bit_en;
                word     = sr;
                perr     = (^sr) ^ d;
            end
            default: ;
        endcase
    end

    // Slot is free if empty or being drained on this same edge.
    assign slot_free = !out.q_valid || out.q_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            ovr         <= 1'b0;
            out.q       <= '0;
            out.q_valid <= 1'b0;
            out.par_err <= 1'b0;
        end else begin
            // Later assignments override earlier ones: a completion beats
            // the drain, an overrun beats the clear.
            if (out.q_valid && out.q_ready) out.q_valid <= 1'b0;
            if (ovr_clr)                    ovr         <= 1'b0;

            if (complete) begin
                if (slot_free) begin
                    out.q       <= word;
                    out.par_err <= perr;
                    out.q_valid <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (bit_en && (d == SIPO_START_BIT)) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (cnt == CNT_LAST) begin
                            state <= PARITY_EN ? PARITY : IDLE;
                            busy  <= PARITY_EN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_en) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
